// File: rtl/cla_multiword_add_ctrl.sv
// Multi-word add/subtract sequencer: one 16-bit carry-lookahead limb per clock,
// LS limb first, with a registered carry chaining the limbs.

module carry_look_ahead_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    logic [15:0] g, p, c;
    logic [3:0]  gg, gp;
    logic [4:0]  gc;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        c  = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        // Second-level lookahead across the four 4-bit groups.
        gc[0] = c_in;
        gc[1] = gg[0] | (gp[0] & c_in);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c_in);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        sum   = p ^ c;
        c_out = gc[4];
    end
endmodule

module cla_multiword_add_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic [16*WORDS-1:0]   a,
    input  logic [16*WORDS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [16*WORDS-1:0]   result,
    output logic                  carry_out,
    output logic                  overflow
);
    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  opa_q, opa_d, opb_q, opb_d, result_q, result_d;
    logic          cout_q, cout_d, ovf_q, ovf_d;
    logic [IW+3:0] base;
    logic [15:0]   add_a, add_b, add_s;
    logic          add_co;

    function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb ~^ b_msb) & (s_msb ^ a_msb);
    endfunction

    assign base  = {idx_q, 4'b0000};
    assign add_a = opa_q[base +: 16];
    assign add_b = opb_q[base +: 16];

    carry_look_ahead_16bit u_cla (
        .a     (add_a),
        .b     (add_b),
        .c_in  (carry_q),
        .sum   (add_s),
        .c_out (add_co)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_RUN: begin
                result_d[base +: 16] = add_s;
                carry_d = add_co;
                if (idx_q == LAST) begin
                    cout_d  = add_co;
                    ovf_d   = ovf_f(opa_q[W-1], opb_q[W-1], add_s[15]);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                // Subtract is a + ~b + 1: the +1 enters as the initial carry.
                if (start) begin
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_cla_multiword_add_ctrl.sv
// Randomized and directed bench for cla_multiword_add_ctrl against a cycle-level
// behavioural model computed with plain wide arithmetic.

module tb_cla_multiword_add_ctrl;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;

    logic         lit_en = 1'b0;
    logic [W-1:0] lit_res = '0;
    logic         lit_c = 1'b0;
    logic         lit_v = 1'b0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         lit;
        logic [W-1:0] lres;
        logic         lc;
        logic         lv;
    } exp_t;

    int   m_rem;
    logic m_done;
    exp_t pend, pub;

    cla_multiword_add_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                   input logic le, input logic [W-1:0] lr, input logic lc, input logic lv);
        exp_t e;
        logic [W:0] wide;
        logic signed [W+1:0] sx, sy, exact;
        sx = $signed({{2{x[W-1]}}, x});
        sy = $signed({{2{y[W-1]}}, y});
        exact = s ? (sx - sy) : (sx + sy);
        wide = {1'b0, x} + {1'b0, y};
        e.res  = s ? (x - y) : (x + y);
        e.c    = s ? (x >= y) : wide[W];
        e.v    = (exact != $signed({{2{exact[W-1]}}, exact[W-1:0]}));
        e.lit  = le;
        e.lres = lr;
        e.lc   = lc;
        e.lv   = lv;
        return e;
    endfunction

    // Timing model: WORDS busy cycles after acceptance, then one done cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            pend   <= '0;
            pub    <= '0;
        end else if (m_rem == 0 && start) begin
            m_rem  <= WORDS;
            m_done <= 1'b0;
            pend   <= model(a, b, sub, lit_en, lit_res, lit_c, lit_v);
        end else if (m_rem > 0) begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1) pub <= pend;
        end else begin
            m_done <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", W'(busy), W'(m_rem != 0));
        chk("done", W'(done), W'(m_done));
        if (m_rem == 0) begin
            chk("result", result, pub.res);
            chk("carry_out", W'(carry_out), W'(pub.c));
            chk("overflow", W'(overflow), W'(pub.v));
        end
        if (m_done && pub.lit) begin
            chk("lit_result", result, pub.lres);
            chk("lit_carry", W'(carry_out), W'(pub.lc));
            chk("lit_overflow", W'(overflow), W'(pub.lv));
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic le,
                         input logic [W-1:0] lr, input logic lc, input logic lv);
        a = x; b = y; sub = s;
        lit_en = le; lit_res = lr; lit_c = lc; lit_v = lv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lit_en = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done();
        for (int i = 0; i < WORDS + 4; i++) begin
            if (done) return;
            @(negedge clk);
        end
        $display("FAIL done_timeout t=%0t got=no_done want=done", $time);
        $fatal(1, "done never arrived");
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0);
        wait_done();
        @(negedge clk);
        issue(64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        wait_done();
        @(negedge clk);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);
        issue(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        wait_done();
        @(negedge clk);

        // A second start while busy must be dropped.
        issue(64'h0001_0000_0000_FFFF, 64'h1, 1'b0, 1'b1, 64'h0001_0000_0001_0000, 1'b0, 1'b0);
        @(negedge clk);
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h1111_1111_1111_1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (WORDS + 2) @(negedge clk);

        // Back-to-back: the next request rides the done cycle.
        issue(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        wait_done();
        issue(64'h3, 64'h4, 1'b0, 1'b1, 64'h7, 1'b0, 1'b0);
        wait_done();
        @(negedge clk);

        // Asynchronous reset two cycles into an operation.
        issue(64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            issue(rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                a = {$urandom, $urandom};
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_done();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        repeat (WORDS + 3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
